// File: rtl/p5_defs.sv
// Shared definitions for the P5 pipeline hazard controller: forwarding
// encodings, Tuse/Tnew constants and the scoreboard entry layout.
package p5_defs;

  // D-stage comparator operand selects
  localparam logic [1:0] FWD_D_RF = 2'd0;
  localparam logic [1:0] FWD_D_E  = 2'd1;
  localparam logic [1:0] FWD_D_M  = 2'd2;

  // E-stage ALU operand selects
  localparam logic [1:0] FWD_E_NONE = 2'd0;
  localparam logic [1:0] FWD_E_M    = 2'd1;
  localparam logic [1:0] FWD_E_W    = 2'd2;

  // Cycles from D until an operand is consumed
  localparam logic [1:0] TUSE_BRANCH = 2'd0;
  localparam logic [1:0] TUSE_ALU    = 2'd1;
  localparam logic [1:0] TUSE_STORE  = 2'd2;

  // Cycles from D until a result is available
  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TNEW_LINK = 2'd1;
  localparam logic [1:0] TNEW_ALU  = 2'd2;
  localparam logic [1:0] TNEW_LOAD = 2'd3;

  typedef struct packed {
    logic [4:0] addr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tnew;
    logic       reg_write;
    logic       md_start;
    logic       md_div;
  } sb_entry_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // $0 is hardwired, so it can never be a producer
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] r);
    return e.reg_write && (e.addr == r) && (r != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sb_stage.sv
// One scoreboard register: loads the upstream entry with Tnew aged by one
// cycle, or an all-zero bubble.
module hazard_sb_stage
  import p5_defs::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      bubble,
  input  sb_entry_t din,
  output sb_entry_t q
);

  sb_entry_t entry_d;
  sb_entry_t entry_q;

  always_comb begin
    entry_d      = din;
    entry_d.tnew = tnew_dec(din.tnew);
    if (bubble) begin
      entry_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q = entry_q;

endmodule

// File: rtl/hazard_ctrl.sv
// P5 hazard controller: E/M/W scoreboard, Tuse/Tnew stall, forwarding
// selects and the mult/div busy window guarding HI/LO accesses.
module hazard_ctrl
  import p5_defs::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       useRsD,
  input  logic       useRtD,
  input  logic [1:0] TuseRsD,
  input  logic [1:0] TuseRtD,
  input  logic [4:0] waddrD,
  input  logic       regWriteD,
  input  logic [1:0] TnewD,
  input  logic       mdStartD,
  input  logic       mdDivD,
  input  logic       mdUseD,
  output logic       stall,
  output logic       clrE,
  output logic [1:0] fwdRsD,
  output logic [1:0] fwdRtD,
  output logic [1:0] fwdRsE,
  output logic [1:0] fwdRtE,
  output logic       mdBusy
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  sb_entry_t d_ent;
  sb_entry_t e_ent;
  sb_entry_t m_ent;
  sb_entry_t w_ent;

  logic [3:0] cnt_d;
  logic [3:0] cnt_q;
  logic       haz_rs;
  logic       haz_rt;
  logic       haz_md;

  always_comb begin
    d_ent           = '0;
    d_ent.addr      = waddrD;
    d_ent.rs        = rsD;
    d_ent.rt        = rtD;
    d_ent.tnew      = TnewD;
    d_ent.reg_write = regWriteD;
    d_ent.md_start  = mdStartD;
    d_ent.md_div    = mdDivD;
  end

  // A stalled D instruction leaves a bubble behind it; M and W keep draining.
  hazard_sb_stage u_sb_e (.clk(clk), .rstn(rstn), .bubble(stall), .din(d_ent), .q(e_ent));
  hazard_sb_stage u_sb_m (.clk(clk), .rstn(rstn), .bubble(1'b0),  .din(e_ent), .q(m_ent));
  hazard_sb_stage u_sb_w (.clk(clk), .rstn(rstn), .bubble(1'b0),  .din(m_ent), .q(w_ent));

  function automatic logic [1:0] fwd_d_sel(input sb_entry_t e, input sb_entry_t m,
                                           input logic [4:0] r);
    if (sb_match(e, r) && (e.tnew == 2'd0)) return FWD_D_E;
    if (sb_match(m, r) && (m.tnew == 2'd0)) return FWD_D_M;
    return FWD_D_RF;
  endfunction

  function automatic logic [1:0] fwd_e_sel(input sb_entry_t m, input sb_entry_t w,
                                           input logic [4:0] r);
    if (sb_match(m, r) && (m.tnew == 2'd0)) return FWD_E_M;
    if (sb_match(w, r)) return FWD_E_W;
    return FWD_E_NONE;
  endfunction

  always_comb begin
    haz_rs = useRsD &&
             ((sb_match(e_ent, rsD) && (e_ent.tnew > TuseRsD)) ||
              (sb_match(m_ent, rsD) && (m_ent.tnew > TuseRsD)));
    haz_rt = useRtD &&
             ((sb_match(e_ent, rtD) && (e_ent.tnew > TuseRtD)) ||
              (sb_match(m_ent, rtD) && (m_ent.tnew > TuseRtD)));
    // A mult/div sitting in E has not loaded the counter yet but still owns HI/LO
    haz_md = mdUseD && (mdBusy || e_ent.md_start);
  end

  assign stall  = haz_rs | haz_rt | haz_md;
  assign clrE   = stall;
  assign fwdRsD = fwd_d_sel(e_ent, m_ent, rsD);
  assign fwdRtD = fwd_d_sel(e_ent, m_ent, rtD);
  assign fwdRsE = fwd_e_sel(m_ent, w_ent, e_ent.rs);
  assign fwdRtE = fwd_e_sel(m_ent, w_ent, e_ent.rt);

  always_comb begin
    cnt_d = cnt_q;
    if (e_ent.md_start) begin
      cnt_d = e_ent.md_div ? DIV_LD : MULT_LD;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mdBusy = (cnt_q != 4'd0);

endmodule
